// File: rtl/cla_pipe_adder_if.sv
// Operand/result bus for the pipelined CLA adder/subtractor.
// Valid/ready on both sides: a beat moves on a rising clk edge where valid and
// ready are both 1; a source holds valid and payload stable until that edge.
interface cla_pipe_adder_if #(
  parameter int nBITS = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [nBITS-1:0] ain;
  logic [nBITS-1:0] bin;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [nBITS-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, ain, bin, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, ain, bin, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: 4-bit lookahead groups spread over
// STAGES register stages, group carry handed from stage to stage.
module cla_pipe_adder #(
  parameter int nBITS  = 16,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  cla_pipe_adder_if.slave   bus
);
  localparam int G    = nBITS / 4;
  localparam int GPS  = (STAGES > 0) ? (G / STAGES) : 1;
  localparam int LAST = STAGES - 1;

  if ((nBITS % 4) != 0 || nBITS < 4) begin : g_bad_width
    $error("cla_pipe_adder: nBITS must be a multiple of 4 and >= 4");
  end
  if (STAGES < 1 || STAGES > G || (G % STAGES) != 0) begin : g_bad_stages
    $error("cla_pipe_adder: STAGES must be 1..nBITS/4 and divide nBITS/4");
  end

  // Returns {c4, c3, sum[3:0]}; c3 is kept because it is the carry into the MSB
  // when this is the top group.
  function automatic logic [5:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic c0);
    logic [3:0] p;
    logic [3:0] g;
    logic       c1;
    logic       c2;
    logic       c3;
    logic       c4;
    p  = a ^ b;
    g  = a & b;
    c1 = g[0] | (p[0] & c0);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c4, c3, p ^ {c3, c2, c1, c0}};
  endfunction

  logic [STAGES-1:0] r_valid;
  logic [nBITS-1:0]  r_sum [STAGES];
  logic [nBITS-1:0]  r_a   [STAGES];
  logic [nBITS-1:0]  r_b   [STAGES];
  logic [STAGES-1:0] r_c;
  logic              r_cm;

  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_src_valid;
  logic [STAGES-1:0] w_nc;
  logic              w_ncm;
  logic [nBITS-1:0]  w_nsum [STAGES];
  logic [nBITS-1:0]  w_sa   [STAGES];
  logic [nBITS-1:0]  w_sb   [STAGES];

  always_comb begin : p_stage_comb
    logic [5:0] w_res;
    logic       w_c;
    int         km;
    int         gi;
    w_adv       = '0;
    w_src_valid = '0;
    w_nc        = '0;
    w_ncm       = 1'b0;
    w_nsum      = '{default: '0};
    w_sa        = '{default: '0};
    w_sb        = '{default: '0};
    w_res       = '0;
    w_c         = 1'b0;
    km          = 0;
    gi          = 0;

    // A stage may load when it is empty or its contents move on this edge.
    w_adv[LAST] = !r_valid[LAST] || bus.out_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      w_adv[k] = !r_valid[k] || w_adv[k+1];
    end

    for (int k = 0; k < STAGES; k++) begin
      km = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        w_src_valid[k] = bus.in_valid;
        w_sa[k]        = bus.ain;
        w_sb[k]        = bus.bin ^ {nBITS{bus.sub}};
        w_c            = bus.sub | bus.cin;
        w_nsum[k]      = '0;
      end else begin
        w_src_valid[k] = r_valid[km];
        w_sa[k]        = r_a[km];
        w_sb[k]        = r_b[km];
        w_c            = r_c[km];
        w_nsum[k]      = r_sum[km];
      end
      for (int j = 0; j < GPS; j++) begin
        gi                    = k * GPS + j;
        w_res                 = cla4(w_sa[k][gi*4 +: 4], w_sb[k][gi*4 +: 4], w_c);
        w_nsum[k][gi*4 +: 4]  = w_res[3:0];
        if (k == LAST) w_ncm  = w_res[4];
        w_c                   = w_res[5];
      end
      w_nc[k] = w_c;
    end
    bus.in_ready = w_adv[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_c     <= '0;
      r_cm    <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_sum[k] <= '0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_adv[k]) begin
          r_valid[k] <= w_src_valid[k];
          r_sum[k]   <= w_nsum[k];
          r_a[k]     <= w_sa[k];
          r_b[k]     <= w_sb[k];
          r_c[k]     <= w_nc[k];
        end
      end
      if (w_adv[LAST]) r_cm <= w_ncm;
    end
  end

  assign bus.out_valid = r_valid[LAST];
  assign bus.sum       = r_sum[LAST];
  assign bus.cout      = r_c[LAST];
  assign bus.ovf       = r_c[LAST] ^ r_cm;
endmodule
